// File: rtl/stack_access_sequencer.sv
// Stack push/pull sequencer: 1 access per byte (+1 pre-read cycle on pulls) then a DONE pulse; req_ready only in IDLE.
// Define STACK_SEQ_DUMMY_READ_EN to issue a real bus read during the pull pre-cycle.
module stack_access_sequencer #(
  parameter logic [7:0] STACK_PAGE = 8'h01
) (
  input  logic        fclk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_pull,
  input  logic [1:0]  req_count,
  input  logic [23:0] push_data,
  input  logic [7:0]  sp_in,
  output logic        sp_increment,
  output logic        sp_decrement,
  output logic [15:0] addr_out,
  output logic        mem_we,
  output logic        mem_re,
  output logic [7:0]  data_out,
  input  logic [7:0]  mem_rdata,
  output logic [23:0] pull_data,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, PUSH, PULL_PRE, PULL, DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  count_q;
  logic [1:0]  index_q;
  logic [23:0] push_q;
  logic [23:0] pull_q;
  logic        last_byte;
  logic [15:0] stack_addr;

  assign last_byte  = (index_q == count_q - 2'd1);
  assign stack_addr = {STACK_PAGE, sp_in};
  assign pull_data  = reset ? 24'h0 : pull_q;

  always_comb begin
    state_d      = state_q;
    req_ready    = 1'b0;
    sp_increment = 1'b0;
    sp_decrement = 1'b0;
    addr_out     = 16'h0000;
    mem_we       = 1'b0;
    mem_re       = 1'b0;
    data_out     = 8'h00;
    done         = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_count == 2'd0) state_d = DONE;
          else if (req_pull)     state_d = PULL_PRE;
          else                   state_d = PUSH;
        end
      end
      PUSH: begin
        mem_we       = 1'b1;
        addr_out     = stack_addr;
        data_out     = push_q[{index_q, 3'b000} +: 8];
        sp_decrement = 1'b1;
        if (last_byte) state_d = DONE;
      end
      PULL_PRE: begin
        // SP points at the last pushed slot's neighbour; step it before the first real read.
        sp_increment = 1'b1;
`ifdef STACK_SEQ_DUMMY_READ_EN
        mem_re       = 1'b1;
        addr_out     = stack_addr;
`endif
        state_d      = PULL;
      end
      PULL: begin
        mem_re       = 1'b1;
        addr_out     = stack_addr;
        sp_increment = !last_byte;
        if (last_byte) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Synchronous reset must already silence the bus in the cycle it is asserted.
    if (reset) begin
      req_ready    = 1'b1;
      sp_increment = 1'b0;
      sp_decrement = 1'b0;
      addr_out     = 16'h0000;
      mem_we       = 1'b0;
      mem_re       = 1'b0;
      data_out     = 8'h00;
      done         = 1'b0;
    end
  end

  always_ff @(posedge fclk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= 2'd0;
      index_q <= 2'd0;
      push_q  <= 24'h0;
      pull_q  <= 24'h0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            count_q <= req_count;
            push_q  <= push_data;
            index_q <= 2'd0;
            if (req_pull) pull_q <= 24'h0;
          end
        end
        PUSH: index_q <= index_q + 2'd1;
        PULL: begin
          pull_q[{index_q, 3'b000} +: 8] <= mem_rdata;
          index_q <= index_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_access_sequencer.sv
// Directed bench for stack_access_sequencer: per-cycle model trace plus literal end-of-transfer checks.
`timescale 1ns/1ps
module tb_stack_access_sequencer;

`ifdef STACK_SEQ_DUMMY_READ_EN
  localparam bit DUMMY = 1'b1;
`else
  localparam bit DUMMY = 1'b0;
`endif

  logic        fclk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_pull;
  logic [1:0]  req_count;
  logic [23:0] push_data, pull_data;
  logic [7:0]  sp;
  logic        sp_increment, sp_decrement, mem_we, mem_re, done;
  logic [15:0] addr_out;
  logic [7:0]  data_out, mem_rdata;

  stack_access_sequencer #(.STACK_PAGE(8'h01)) dut (
    .fclk(fclk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_pull(req_pull), .req_count(req_count), .push_data(push_data), .sp_in(sp),
    .sp_increment(sp_increment), .sp_decrement(sp_decrement), .addr_out(addr_out),
    .mem_we(mem_we), .mem_re(mem_re), .data_out(data_out), .mem_rdata(mem_rdata),
    .pull_data(pull_data), .done(done)
  );

  always #5 fclk = ~fclk;

  typedef struct packed {
    logic rdy, inc, dec, we, re, dn;
    logic [15:0] addr;
    logic [7:0]  dout;
    logic [23:0] pdata;
  } obs_t;

  // Stack pointer register and stack page memory owned by the bench
  logic       sp_ld;
  logic [7:0] sp_ld_val;
  always @(posedge fclk)
    if (sp_ld) sp <= sp_ld_val;
    else if (sp_decrement) sp <= sp - 8'd1;
    else if (sp_increment) sp <= sp + 8'd1;

  logic [7:0] mem [256];
  logic       bd_we;
  logic [7:0] bd_a, bd_d;
  always @(posedge fclk)
    if (bd_we) mem[bd_a] <= bd_d;
    else if (mem_we) mem[addr_out[7:0]] <= data_out;
  assign mem_rdata = mem_re ? mem[addr_out[7:0]] : 8'h00;

  int cyc = 0;
  always @(posedge fclk) cyc <= cyc + 1;

  int n_checks = 0, n_fail = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor of strobes and completion
  int inc_cnt = 0, dec_cnt = 0, re_cnt = 0, done_cnt = 0, done_cyc = 0;
  logic [23:0] done_pdata;
  logic [15:0] wr_q[$];
  always @(negedge fclk) begin
    if (sp_increment) inc_cnt++;
    if (sp_decrement) dec_cnt++;
    if (mem_re) re_cnt++;
    if (mem_we) wr_q.push_back(addr_out);
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      done_pdata = pull_data;
    end
  end

  // Model state and per-cycle expectations
  obs_t        exp_q[$];
  string       tag_q[$];
  logic [7:0]  ref_mem [256];
  logic [7:0]  model_sp;
  logic [23:0] model_pdata;
  int          acc_cyc;

  always @(negedge fclk) begin
    if (exp_q.size() > 0) begin
      obs_t  e, a;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a.rdy = req_ready;  a.inc = sp_increment; a.dec = sp_decrement;
      a.we = mem_we;      a.re = mem_re;        a.dn = done;
      a.addr = addr_out;  a.dout = data_out;    a.pdata = pull_data;
      chk(t, 64'(a), 64'(e));
      chk({t, "_excl"}, {62'b0, sp_increment & sp_decrement, mem_we & mem_re}, 64'h0);
    end
  end

  function automatic obs_t idle_rec();
    obs_t r;
    r = '0;
    r.rdy = 1'b1;
    r.pdata = model_pdata;
    return r;
  endfunction

  task automatic next_cycle();
    @(posedge fclk);
    #1;
  endtask

  task automatic exp_cyc(input obs_t e, input string t);
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      next_cycle();
      req_valid = 1'b0;
      sp_ld = 1'b0;
      exp_cyc(idle_rec(), "idle");
    end
  endtask

  task automatic set_sp(input logic [7:0] v);
    next_cycle();
    req_valid = 1'b0; sp_ld = 1'b1; sp_ld_val = v;
    exp_cyc(idle_rec(), "sp_load");
    next_cycle();
    sp_ld = 1'b0;
    exp_cyc(idle_rec(), "sp_load2");
    model_sp = v;
  endtask

  // Busy-cycle inputs: either drop the request or keep it asserted with garbage
  task automatic busy_inputs(input bit hold);
    if (!hold) req_valid = 1'b0;
    else begin
      req_pull = ~req_pull;
      req_count = 2'd3;
      push_data = ~push_data;
    end
  endtask

  task automatic run(input bit pull, input int n, input logic [23:0] d, input bit hold, input string t);
    logic [7:0] sp0, b;
    obs_t e;
    sp0 = model_sp;
    next_cycle();
    sp_ld = 1'b0; req_valid = 1'b1; req_pull = pull; req_count = 2'(n); push_data = d;
    acc_cyc = cyc;
    exp_cyc(idle_rec(), {t, "_accept"});
    if (pull) model_pdata = 24'h0;
    if (pull && n > 0) begin
      next_cycle(); busy_inputs(hold);
      e = '0; e.inc = 1'b1; e.re = DUMMY;
      e.addr = DUMMY ? {8'h01, sp0} : 16'h0000;
      e.pdata = model_pdata;
      exp_cyc(e, {t, "_pre"});
      for (int i = 0; i < n; i++) begin
        next_cycle(); busy_inputs(hold);
        b = sp0 + 8'(i + 1);
        e = '0; e.re = 1'b1; e.addr = {8'h01, b}; e.inc = (i != n - 1); e.pdata = model_pdata;
        exp_cyc(e, $sformatf("%s_rd%0d", t, i));
        model_pdata[8*i +: 8] = ref_mem[b];
      end
      model_sp = sp0 + 8'(n);
    end else if (!pull) begin
      for (int i = 0; i < n; i++) begin
        next_cycle(); busy_inputs(hold);
        b = sp0 - 8'(i);
        e = '0; e.we = 1'b1; e.dec = 1'b1; e.addr = {8'h01, b}; e.dout = d[8*i +: 8];
        e.pdata = model_pdata;
        exp_cyc(e, $sformatf("%s_wr%0d", t, i));
        ref_mem[b] = d[8*i +: 8];
      end
      model_sp = sp0 - 8'(n);
    end
    next_cycle(); busy_inputs(hold);
    e = '0; e.dn = 1'b1; e.pdata = model_pdata;
    exp_cyc(e, {t, "_done"});
  endtask

  int inc0, dec0, re0, done0, n_wr;
  obs_t rrec, e;
  logic [7:0] pk_a [5];
  logic [7:0] pk_d [5];

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_pull = 1'b0; req_count = 2'd0; push_data = 24'h0;
    sp_ld = 1'b0; sp_ld_val = 8'h00; bd_we = 1'b0; bd_a = 8'h00; bd_d = 8'h00;
    model_pdata = 24'h0; model_sp = 8'h00;
    rrec = '0; rrec.rdy = 1'b1;
    pk_a = '{8'hFB, 8'hFC, 8'h2F, 8'h2E, 8'h40};
    pk_d = '{8'hCD, 8'hAB, 8'hEE, 8'hDD, 8'h77};

    for (int k = 0; k < 5; k++) begin
      next_cycle();
      bd_we = 1'b1; bd_a = pk_a[k]; bd_d = pk_d[k];
      ref_mem[pk_a[k]] = pk_d[k];
      exp_cyc(rrec, "reset");
    end
    next_cycle();
    bd_we = 1'b0; reset = 1'b0;
    exp_cyc(idle_rec(), "post_reset");

    // Pull 2 from SP=FA
    set_sp(8'hFA);
    inc0 = inc_cnt; re0 = re_cnt;
    run(1'b1, 2, 24'h0, 1'b0, "pull2");
    idle(1);
    chk("pull2_data", done_pdata, 24'h00ABCD);
    chk("pull2_incs", inc_cnt - inc0, 2);
    chk("pull2_reads", re_cnt - re0, DUMMY ? 3 : 2);
    chk("pull2_done_cyc", done_cyc - acc_cyc, 4);
    chk("pull2_sp", sp, 8'hFC);

    // Push 3 from SP=FD
    set_sp(8'hFD);
    dec0 = dec_cnt; wr_q.delete();
    run(1'b0, 3, 24'h563412, 1'b0, "push3");
    idle(1);
    chk("push3_mem_fd", mem[8'hFD], 8'h12);
    chk("push3_mem_fc", mem[8'hFC], 8'h34);
    chk("push3_mem_fb", mem[8'hFB], 8'h56);
    chk("push3_decs", dec_cnt - dec0, 3);
    chk("push3_done_cyc", done_cyc - acc_cyc, 4);
    chk("push3_sp", sp, 8'hFA);

    // Push 2 across the 00 -> FF wrap
    set_sp(8'h00);
    wr_q.delete();
    run(1'b0, 2, 24'h00BEEF, 1'b0, "push_wrap");
    idle(1);
    n_wr = wr_q.size();
    chk("wrap_nwrites", n_wr, 2);
    if (n_wr == 2) begin
      chk("wrap_addr0", wr_q[0], 16'h0100);
      chk("wrap_addr1", wr_q[1], 16'h01FF);
    end
    chk("wrap_mem_ff", mem[8'hFF], 8'hBE);
    chk("wrap_sp", sp, 8'hFE);

    // Reset during the second cycle of a 3-byte push
    set_sp(8'h30);
    dec0 = dec_cnt; wr_q.delete();
    next_cycle();
    req_valid = 1'b1; req_pull = 1'b0; req_count = 2'd3; push_data = 24'hCCBBAA;
    exp_cyc(idle_rec(), "rst_accept");
    next_cycle();
    req_valid = 1'b0;
    e = '0; e.we = 1'b1; e.dec = 1'b1; e.addr = 16'h0130; e.dout = 8'hAA; e.pdata = model_pdata;
    exp_cyc(e, "rst_push0");
    ref_mem[8'h30] = 8'hAA;
    next_cycle();
    reset = 1'b1;
    exp_cyc(rrec, "rst_mid");
    next_cycle();
    reset = 1'b0;
    model_pdata = 24'h0; model_sp = 8'h2F;
    exp_cyc(idle_rec(), "rst_after");
    idle(2);
    chk("rst_nwrites", wr_q.size(), 1);
    chk("rst_mem_2f", mem[8'h2F], 8'hEE);
    chk("rst_mem_2e", mem[8'h2E], 8'hDD);
    chk("rst_decs", dec_cnt - dec0, 1);
    chk("rst_sp", sp, 8'h2F);

    // Pull 1 with req_valid held high and inputs changing while busy
    set_sp(8'h3F);
    inc0 = inc_cnt; re0 = re_cnt; done0 = done_cnt;
    run(1'b1, 1, 24'h0, 1'b1, "hold_pull1");
    idle(1);
    chk("hold_data", done_pdata, 24'h000077);
    chk("hold_dones", done_cnt - done0, 1);
    chk("hold_incs", inc_cnt - inc0, 1);
    chk("hold_reads", re_cnt - re0, DUMMY ? 2 : 1);
    chk("hold_done_cyc", done_cyc - acc_cyc, 3);

    // Count 0 push keeps pull_data; count 0 pull clears it
    inc0 = inc_cnt; dec0 = dec_cnt; re0 = re_cnt; done0 = done_cnt; wr_q.delete();
    run(1'b0, 0, 24'h123456, 1'b0, "push0");
    idle(1);
    chk("push0_done_cyc", done_cyc - acc_cyc, 1);
    chk("push0_hold_pdata", done_pdata, 24'h000077);
    run(1'b1, 0, 24'h0, 1'b0, "pull0");
    idle(1);
    chk("pull0_done_cyc", done_cyc - acc_cyc, 1);
    chk("pull0_clear", done_pdata, 24'h000000);
    chk("cnt0_dones", done_cnt - done0, 2);
    chk("cnt0_strobes", (inc_cnt - inc0) + (dec_cnt - dec0) + (re_cnt - re0) + wr_q.size(), 0);

    idle(1);
    @(negedge fclk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
